// File: rtl/uart_echo_fifo_if.sv
// Receiver/transmitter handshake bundle between rcvr, txmit and the echo bridge.
// The bridge takes the slave view; the UART side (or a bench) takes the master view.
interface uart_echo_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rbr;
  logic              rdrdy;
  logic              rdrst;
  logic              tbuf;
  logic [DATA_W-1:0] tdin;
  logic              wrn;

  modport master (
    output rbr, rdrdy, tbuf,
    input  rdrst, tdin, wrn
  );

  modport slave (
    input  rbr, rdrdy, tbuf,
    output rdrst, tdin, wrn
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// UART receive-to-transmit echo bridge with an internal word FIFO, rdrst/wrn handshakes and overflow flag.
// Optional: define UART_ECHO_UPCASE_EN to fold ASCII lowercase to uppercase on load into tdin.
module uart_echo_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int TBUF_WAIT  = 16
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  uart_echo_fifo_if.slave       bus,
  input  logic                  clr_ovf,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = $clog2(TBUF_WAIT + 1);

  typedef enum logic [1:0] {R_CLR, R_REL, R_WAIT} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_STRB, T_ACK, T_DRAIN} tx_state_t;

  rx_state_t               rx_state;
  tx_state_t               tx_state;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr;
  logic [DEPTH_LOG2-1:0]   rptr;
  logic [TW-1:0]           timer;
  logic [CW-1:0]           count_nxt;
  logic                    rx_take;
  logic                    push;
  logic                    pop;
  logic                    drop;

  function automatic logic [DATA_W-1:0] load_word(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = w;
`ifdef UART_ECHO_UPCASE_EN
    if (DATA_W >= 8 && w[7:0] >= 8'h61 && w[7:0] <= 8'h7A) r[5] = 1'b0;
`endif
    return r;
  endfunction

  // A pop at full frees the slot the simultaneous push needs, so that push is not a drop.
  always_comb begin
    pop       = (tx_state == T_IDLE) && !empty && !bus.tbuf;
    rx_take   = (rx_state == R_WAIT) && bus.rdrdy;
    push      = rx_take && (!full || pop);
    drop      = rx_take && full && !pop;
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rx_state  <= R_CLR;
      bus.rdrst <= 1'b0;
    end else begin
      case (rx_state)
        R_CLR: begin
          bus.rdrst <= 1'b1;
          rx_state  <= R_REL;
        end
        R_REL: begin
          bus.rdrst <= 1'b0;
          rx_state  <= R_WAIT;
        end
        R_WAIT: begin
          if (bus.rdrdy) begin
            bus.rdrst <= 1'b1;
            rx_state  <= R_REL;
          end
        end
        default: begin
          bus.rdrst <= 1'b0;
          rx_state  <= R_CLR;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tx_state <= T_IDLE;
      bus.wrn  <= 1'b0;
      bus.tdin <= '0;
      timer    <= '0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (pop) begin
            bus.tdin <= load_word(mem[rptr]);
            bus.wrn  <= 1'b1;
            tx_state <= T_STRB;
          end
        end
        T_STRB: begin
          bus.wrn  <= 1'b0;
          timer    <= '0;
          tx_state <= T_ACK;
        end
        // No retry on timeout: the word is treated as sent.
        T_ACK: begin
          if (bus.tbuf)                        tx_state <= T_DRAIN;
          else if (timer == TW'(TBUF_WAIT - 1)) tx_state <= T_IDLE;
          else                                 timer    <= timer + TW'(1);
        end
        T_DRAIN: begin
          if (!bus.tbuf) tx_state <= T_IDLE;
        end
        default: begin
          bus.wrn  <= 1'b0;
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + DEPTH_LOG2'(1);
      if (pop)  rptr <= rptr + DEPTH_LOG2'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= bus.rbr;
  end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboard bench for uart_echo_fifo: randomized and directed traffic against a queue-based reference.
module tb_uart_echo_fifo;
  localparam int DATA_W     = 8;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;
  localparam int TBUF_WAIT  = 5;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                clr_ovf = 1'b0;
  logic [DEPTH_LOG2:0] count;
  logic                empty;
  logic                full;
  logic                ovf;
  logic                tbuf_man = 1'b1;
  logic                tbuf_emu = 1'b0;
  bit                  mode_emu = 1'b0;

  uart_echo_fifo_if #(.DATA_W(DATA_W)) bus();

  assign bus.tbuf = mode_emu ? tbuf_emu : tbuf_man;

  uart_echo_fifo #(
    .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .TBUF_WAIT(TBUF_WAIT)
  ) dut (
    .CLK(clk), .RSTN(rstn), .bus(bus), .clr_ovf(clr_ovf),
    .count(count), .empty(empty), .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  sb[$];
  int          wrn_cyc[$];
  bit          exp_ovf = 1'b0;
  bit          prev_wrn = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference view of what the transmitter should receive for a captured character.
  function automatic logic [7:0] exp_tx(input logic [7:0] w);
`ifdef UART_ECHO_UPCASE_EN
    if (w >= "a" && w <= "z") return w - 8'd32;
`endif
    return w;
  endfunction

  // Monitor: every wrn strobe is matched against the head of the expected queue,
  // and occupancy flags are compared with the number of words still owed.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      prev_wrn = 1'b0;
    end else begin
      if (bus.wrn) begin
        check("wrn_width", 32'(prev_wrn), 32'(0));
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'(1));
        end else begin
          check("tdin", 32'(bus.tdin), 32'(sb.pop_front()));
        end
        wrn_cyc.push_back(cyc);
      end
      prev_wrn = bus.wrn;
      check("count", 32'(count), 32'(sb.size()));
      check("empty", 32'(empty), 32'(sb.size() == 0));
      check("full",  32'(full),  32'(sb.size() == DEPTH));
    end
  end

  // Transmitter model: goes busy after most strobes, occasionally never answers.
  initial begin
    int busy;
    busy = 0;
    forever begin
      @(negedge clk);
      if (!mode_emu || !rstn) begin
        busy = 0;
        tbuf_emu = 1'b0;
      end else if (busy > 0) begin
        busy--;
        tbuf_emu = (busy != 0);
      end else if (bus.wrn && $urandom_range(0, 4) != 0) begin
        busy = $urandom_range(1, 6);
        tbuf_emu = 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] w, input bit release_tbuf, input bit clr);
    bit pop_now;
    @(negedge clk);
    bus.rbr = w;
    bus.rdrdy = 1'b1;
    if (clr) clr_ovf = 1'b1;
    if (release_tbuf) tbuf_man = 1'b0;
    pop_now = release_tbuf && (sb.size() > 0);
    @(posedge clk);
    if (sb.size() < DEPTH || pop_now) begin
      sb.push_back(exp_tx(w));
      if (clr) exp_ovf = 1'b0;
    end else begin
      exp_ovf = 1'b1;
    end
    @(negedge clk);
    bus.rdrdy = 1'b0;
    clr_ovf = 1'b0;
    if (release_tbuf) tbuf_man = 1'b1;
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    clr_ovf = 1'b1;
    @(posedge clk);
    exp_ovf = 1'b0;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sb.size()), 32'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rdrst"}, 32'(bus.rdrst), 32'(0));
    check({tag, "_wrn"},   32'(bus.wrn),   32'(0));
    check({tag, "_tdin"},  32'(bus.tdin),  32'(0));
    check({tag, "_count"}, 32'(count),     32'(0));
    check({tag, "_empty"}, 32'(empty),     32'(1));
    check({tag, "_full"},  32'(full),      32'(0));
    check({tag, "_ovf"},   32'(ovf),       32'(0));
  endtask

  task automatic release_and_check_startup(input string tag);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check({tag, "_rdrst_hi"}, 32'(bus.rdrst), 32'(1));
    check({tag, "_wrn"},      32'(bus.wrn),   32'(0));
    @(negedge clk);
    check({tag, "_rdrst_lo"}, 32'(bus.rdrst), 32'(0));
    check({tag, "_count"},    32'(count),     32'(0));
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] exp_lc;
    int         n;
    bus.rbr = '0;
    bus.rdrdy = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    release_and_check_startup("startup");

    // Single echo with idle transmitter: wrn two edges after capture.
    tbuf_man = 1'b0;
    send(8'h41, 1'b0, 1'b0);
    check("echo_rdrst", 32'(bus.rdrst), 32'(1));
    check("echo_wrn_early", 32'(bus.wrn), 32'(0));
    @(negedge clk);
    check("echo_wrn", 32'(bus.wrn), 32'(1));
    check("echo_tdin", 32'(bus.tdin), 32'(8'h41));
    check("echo_count", 32'(count), 32'(0));
    repeat (TBUF_WAIT + 4) @(negedge clk);

`ifdef UART_ECHO_UPCASE_EN
    exp_lc = 8'h41;
`else
    exp_lc = 8'h61;
`endif
    send(8'h61, 1'b0, 1'b0);
    @(negedge clk);
    check("lower_a_tdin", 32'(bus.tdin), 32'(exp_lc));
    repeat (TBUF_WAIT + 4) @(negedge clk);
    send(8'h7B, 1'b0, 1'b0);
    @(negedge clk);
    check("brace_tdin", 32'(bus.tdin), 32'(8'h7B));
    repeat (TBUF_WAIT + 4) @(negedge clk);

    // Randomized traffic with an emulated transmitter.
    mode_emu = 1'b1;
    for (int i = 0; i < 80; i++) begin
      n = 0;
      while (sb.size() >= 12 && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (n >= 300) check("rand_backlog_timeout", 32'(sb.size()), 32'(0));
      if ($urandom_range(0, 3) == 0) w = 8'($urandom_range(8'h5F, 8'h7C));
      else                           w = 8'($urandom_range(0, 255));
      send(w, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain("rand_drain");
    repeat (20) @(negedge clk);
    check("rand_no_ovf", 32'(ovf), 32'(0));

    // Burst into a stalled transmitter until the FIFO overflows.
    @(negedge clk);
    tbuf_man = 1'b1;
    mode_emu = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) send(8'(i), 1'b0, 1'b0);
    check("burst_count", 32'(count), 32'(DEPTH));
    check("burst_full", 32'(full), 32'(1));
    check("burst_ovf", 32'(ovf), 32'(exp_ovf));
    check("burst_ovf_set", 32'(exp_ovf), 32'(1));
    clear_ovf();

    // Push and pop on the same edge while full.
    send(8'h55, 1'b1, 1'b0);
    check("simul_count", 32'(count), 32'(DEPTH));
    check("simul_ovf", 32'(ovf), 32'(exp_ovf));

    // Clear request loses to a new overflow on the same edge.
    send(8'h66, 1'b0, 1'b1);
    check("clr_vs_ovf", 32'(ovf), 32'(1));
    check("clr_vs_ovf_model", 32'(ovf), 32'(exp_ovf));

    mode_emu = 1'b1;
    wait_drain("burst_drain");
    repeat (20) @(negedge clk);
    check("drain_ovf_sticky", 32'(ovf), 32'(1));

    // Transmitter never acknowledges: second strobe after the timeout.
    @(negedge clk);
    mode_emu = 1'b0;
    tbuf_man = 1'b0;
    wrn_cyc.delete();
    send(8'h21, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    repeat (2 * TBUF_WAIT + 8) @(negedge clk);
    check("timeout_strobes", 32'(wrn_cyc.size()), 32'(2));
    if (wrn_cyc.size() >= 2)
      check("timeout_gap", 32'(wrn_cyc[1] - wrn_cyc[0]), 32'(TBUF_WAIT + 2));

    // Reset while waiting for the transmitter acknowledge with 5 words queued.
    @(negedge clk);
    tbuf_man = 1'b1;
    for (int i = 0; i < 6; i++) send(8'(8'h31 + i), 1'b0, 1'b0);
    check("prerst_count6", 32'(count), 32'(6));
    @(negedge clk);
    tbuf_man = 1'b0;
    n = 0;
    while (!bus.wrn && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("prerst_wrn_seen", 32'(bus.wrn), 32'(1));
    @(negedge clk);
    check("prerst_count5", 32'(count), 32'(5));
    rstn = 1'b0;
    exp_ovf = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    release_and_check_startup("restart");

    send(8'h5A, 1'b0, 1'b0);
    repeat (TBUF_WAIT + 6) @(negedge clk);
    check("restart_drained", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
